// File: rtl/window_pkg.sv
// rtl/window_pkg.sv - shared state encoding and arithmetic helpers for the KxK window writer.
package window_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } ww_state_e;

    // Index width for a dimension of size m; never narrower than one bit.
    function automatic int pos_width(input int m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    // Unsigned add of two w-bit values, clamped to 2^w-1 (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/window_row_writer.sv
// rtl/window_row_writer.sv - next-state value of one frame row given one latched window row.
module window_row_writer
    import window_pkg::*;
#(
    parameter int K  = 3,
    parameter int M  = 8,
    parameter int W  = 8,
    parameter int IW = pos_width(M)
) (
    input  logic [0:M-1][W-1:0] cur_row,
    input  logic [0:K-1][W-1:0] win_row,
    input  logic [IW-1:0]       col,
    input  logic                en,
    output logic [0:M-1][W-1:0] next_row
);

    always_comb begin
        next_row = cur_row;
        for (int c = 0; c < K; c++) begin
            logic [IW:0] idx;
            idx = {1'b0, col} + (IW+1)'(c);
            if (en && (idx < (IW+1)'(M))) begin
`ifdef WINDOW_WRITER_ACCUM_EN
                next_row[idx[IW-1:0]] = W'(sat_add(32'(cur_row[idx[IW-1:0]]), 32'(win_row[c]), W));
`else
                next_row[idx[IW-1:0]] = win_row[c];
`endif
            end
        end
    end

endmodule

// File: rtl/window_writer_kxk.sv
// rtl/window_writer_kxk.sv - writes a KxK window into a registered MxM frame, one row per cycle.
// Define WINDOW_WRITER_ACCUM_EN to saturating-accumulate into the frame instead of overwriting.
module window_writer_kxk
    import window_pkg::*;
#(
    parameter int K  = 3,
    parameter int M  = 8,
    parameter int W  = 8,
    parameter int IW = pos_width(M)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [0:K-1][0:K-1][W-1:0]    win,
    input  logic [IW-1:0]                 row,
    input  logic [IW-1:0]                 col,
    output logic [0:M-1][0:M-1][W-1:0]    frame,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int RW = pos_width(K);

    ww_state_e                    state;
    logic [RW-1:0]                r_cnt;
    logic [0:K-1][0:K-1][W-1:0]   win_q;
    logic [IW-1:0]                row_q;
    logic [IW-1:0]                col_q;

    logic [IW:0]                  row_end;
    logic [IW:0]                  col_end;
    logic                         oob;
    logic [IW-1:0]                tgt;
    logic [0:M-1][W-1:0]          next_row;

    // One extra bit so row+K cannot wrap before the compare against M.
    assign row_end  = {1'b0, row} + (IW+1)'(K);
    assign col_end  = {1'b0, col} + (IW+1)'(K);
    assign oob      = (row_end > (IW+1)'(M)) || (col_end > (IW+1)'(M));

    assign tgt      = row_q + IW'(r_cnt);
    assign in_ready = (state == IDLE) && !clear;
    assign busy     = (state != IDLE);

    window_row_writer #(
        .K  (K),
        .M  (M),
        .W  (W),
        .IW (IW)
    ) u_row_writer (
        .cur_row  (frame[tgt]),
        .win_row  (win_q[r_cnt]),
        .col      (col_q),
        .en       (state == WRITE),
        .next_row (next_row)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            r_cnt <= '0;
            frame <= '0;
            win_q <= '0;
            row_q <= '0;
            col_q <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        frame <= '0;
                    end else if (in_valid) begin
                        win_q <= win;
                        row_q <= row;
                        col_q <= col;
                        r_cnt <= '0;
                        if (oob) begin
                            err <= 1'b1;
                        end else begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    frame[tgt] <= next_row;
                    if (r_cnt == RW'(K-1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + RW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_writer_kxk.sv
// tb/tb_window_writer_kxk.sv - directed self-checking bench for window_writer_kxk.
module tb_window_writer_kxk;

    localparam int K  = 3;
    localparam int M  = 8;
    localparam int W  = 8;
    localparam int IW = 3;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          clear;
    logic                          in_valid;
    logic                          in_ready;
    logic [0:K-1][0:K-1][W-1:0]    win;
    logic [IW-1:0]                 row;
    logic [IW-1:0]                 col;
    logic [0:M-1][0:M-1][W-1:0]    frame;
    logic                          busy;
    logic                          done;
    logic                          err;

    logic [0:M-1][0:M-1][W-1:0]    mdl;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int r;
        int c;
        int base;
        int step;
        bit exp_err;
        int cr;
        int cc;
        int cv;
    } vec_t;

    vec_t tbl[6];

    window_writer_kxk #(.K(K), .M(M), .W(W), .IW(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .win      (win),
        .row      (row),
        .col      (col),
        .frame    (frame),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name);
        int bad;
        int br;
        int bc;
        bad = 0;
        br  = 0;
        bc  = 0;
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < M; c++) begin
                if (frame[r][c] !== mdl[r][c]) begin
                    if (bad == 0) begin
                        br = r;
                        bc = c;
                    end
                    bad++;
                end
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: frame[%0d][%0d] got %0d expected %0d (%0d elements differ)",
                     name, br, bc, frame[br][bc], mdl[br][bc], bad);
        end
    endtask

    function automatic logic [W-1:0] wval(input int base, input int step, input int r, input int c);
        return W'(base + step * (r * K + c));
    endfunction

    task automatic make_win(input int base, input int step);
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                win[r][c] = wval(base, step, r, c);
    endtask

    task automatic model_write(input int r0, input int c0, input int base, input int step);
        int s;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
`ifdef WINDOW_WRITER_ACCUM_EN
                s = int'(mdl[r0+r][c0+c]) + int'(wval(base, step, r, c));
                if (s > (1 << W) - 1) s = (1 << W) - 1;
                mdl[r0+r][c0+c] = W'(s);
`else
                s = int'(wval(base, step, r, c));
                mdl[r0+r][c0+c] = W'(s);
`endif
            end
        end
    endtask

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({name, " ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic apply(input string name, input int r0, input int c0, input int base,
                         input int step, input bit exp_err);
        int done_cnt;
        int done_at;
        wait_ready(name);
        make_win(base, step);
        row      = IW'(r0);
        col      = IW'(c0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        win      = '1;
        row      = '1;
        col      = '1;
        if (exp_err) begin
            check({name, " err"}, 32'(err), 32'd1);
            check({name, " err busy"}, 32'(busy), 32'd0);
            check({name, " err in_ready"}, 32'(in_ready), 32'd1);
            @(negedge clk);
            check({name, " err pulse"}, 32'(err), 32'd0);
            check({name, " err no done"}, 32'(done), 32'd0);
        end else begin
            model_write(r0, c0, base, step);
            check({name, " busy"}, 32'(busy), 32'd1);
            check({name, " in_ready low"}, 32'(in_ready), 32'd0);
            done_cnt = 0;
            done_at  = 0;
            for (int i = 1; i <= K + 1; i++) begin
                @(negedge clk);
                if (done) begin
                    done_cnt++;
                    done_at = i;
                end
            end
            check({name, " done count"}, 32'(done_cnt), 32'd1);
            check({name, " done cycle"}, 32'(done_at), 32'(K));
            check({name, " idle"}, 32'(busy), 32'd0);
        end
        check_frame({name, " frame"});
    endtask

    initial begin
        int acc[$];
        int mis;

        tbl[0] = '{0, 0,  1, 1, 1'b0, 2, 2,  9};
        tbl[1] = '{5, 5, 10, 1, 1'b0, 7, 7, 18};
        tbl[2] = '{6, 0, 50, 1, 1'b1, 0, 0,  1};
        tbl[3] = '{0, 6, 60, 1, 1'b1, 7, 7, 18};
        tbl[4] = '{2, 3, 30, 1, 1'b0, 4, 5, 38};
        tbl[5] = '{7, 7, 70, 1, 1'b1, 2, 3, 30};

        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        win      = '0;
        row      = '0;
        col      = '0;
        mdl      = '0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_frame("reset frame");
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);

        // Row-per-cycle timing for a 1..9 window at (0,0).
        make_win(1, 1);
        row = '0;
        col = '0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        win = '0;
        check("e0 no bypass", 32'(frame[0][0]), 32'd0);
        @(negedge clk);
        check("e1 row0", 32'({frame[0][0], frame[0][1], frame[0][2]}), 32'h010203);
        check("e1 row1 untouched", 32'(frame[1][0]), 32'd0);
        check("e1 done", 32'(done), 32'd0);
        @(negedge clk);
        check("e2 row1", 32'({frame[1][0], frame[1][1], frame[1][2]}), 32'h040506);
        check("e2 done", 32'(done), 32'd0);
        @(negedge clk);
        check("e3 row2", 32'({frame[2][0], frame[2][1], frame[2][2]}), 32'h070809);
        check("e3 done", 32'(done), 32'd1);
        check("e3 outside", 32'(frame[3][3]), 32'd0);
        @(negedge clk);
        check("e4 done low", 32'(done), 32'd0);
        check("e4 in_ready", 32'(in_ready), 32'd1);
        model_write(0, 0, 1, 1);
        check_frame("timing frame");

        // Asynchronous reset in the middle of a write.
        make_win(9, 0);
        row = IW'(4);
        col = IW'(4);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("midwrite row4", 32'(frame[4][4]), 32'd9);
        rst = 1'b1;
        #1;
        mdl = '0;
        check_frame("midwrite reset frame");
        check("midwrite in_ready", 32'(in_ready), 32'd1);
        check("midwrite busy", 32'(busy), 32'd0);
        check("midwrite done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            apply($sformatf("vec%0d", v), tbl[v].r, tbl[v].c, tbl[v].base, tbl[v].step, tbl[v].exp_err);
            check($sformatf("vec%0d elem", v), 32'(frame[tbl[v].cr][tbl[v].cc]), 32'(tbl[v].cv));
        end

        // Back-to-back with in_valid held high.
        wait_ready("b2b");
        make_win(5, 2);
        row = IW'(3);
        col = IW'(0);
        in_valid = 1'b1;
        mis = 0;
        for (int j = 0; j < 12; j++) begin
            if (in_ready) acc.push_back(j);
            if (in_ready == busy) mis++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b accepts", 32'(acc.size()), 32'd3);
        if (acc.size() == 3) begin
            check("b2b spacing1", 32'(acc[1] - acc[0]), 32'(K + 2));
            check("b2b spacing2", 32'(acc[2] - acc[1]), 32'(K + 2));
        end
        check("b2b ready vs busy", 32'(mis), 32'd0);
        for (int n = 0; n < 3; n++) model_write(3, 0, 5, 2);
        wait_ready("b2b end");
        check_frame("b2b frame");

        // clear wins over in_valid in IDLE; the window goes in one cycle later.
        make_win(3, 0);
        row = '0;
        col = '0;
        in_valid = 1'b1;
        clear = 1'b1;
        #1;
        check("clear in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        mdl = '0;
        check_frame("clear frame");
        check("clear no accept", 32'(busy), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("post-clear accept", 32'(busy), 32'd1);
        model_write(0, 0, 3, 0);
        wait_ready("post-clear");
        check_frame("post-clear frame");

        // clear during WRITE is ignored.
        make_win(4, 0);
        row = IW'(4);
        col = IW'(4);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_write(4, 4, 4, 0);
        wait_ready("clear in write");
        check_frame("clear in write frame");

        // Overlap of an all-200 window with an all-100 window.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        mdl = '0;
        apply("ovl a", 0, 0, 200, 0, 1'b0);
        apply("ovl b", 1, 1, 100, 0, 1'b0);
`ifdef WINDOW_WRITER_ACCUM_EN
        check("ovl [1][1]", 32'(frame[1][1]), 32'd255);
`else
        check("ovl [1][1]", 32'(frame[1][1]), 32'd100);
`endif
        check("ovl [0][0]", 32'(frame[0][0]), 32'd200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/window_writer_kxk.md
Name: window_writer_kxk

Overview:
- Inverse of the KxK window extractor: accepts a KxK window plus a start position (row, col) and writes it back into an internally held MxM frame.
- Writing is serialized at one window row per cycle.
- Sits at the output end of the window-processing path (after per-window compute) and reassembles results into a full matrix for downstream MaxNet stages.

Parameters:
- K, 3, window edge length.
- M, 8, frame edge length; K <= M.
- W, 8, element width in bits.
- IW, $clog2(M), width of row/col position inputs.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  zero the whole frame (honoured only in IDLE).
- in_valid  in  1  window and position are valid.
- in_ready  out  1  block can accept a window this cycle.
- win  in  [W-1:0][0:K-1][0:K-1]  window data.
- row  in  IW  top-left row of the target location.
- col  in  IW  top-left column of the target location.
- frame  out  [W-1:0][0:M-1][0:M-1]  registered frame contents.
- busy  out  1  write in progress (WRITE or DONE state).
- done  out  1  one-cycle pulse after the last row of a window is written.
- err  out  1  one-cycle pulse when a window is rejected as out of bounds.

Behaviour:
- Reset (async, active-high): frame all zero, state IDLE, done=0, err=0, busy=0, row counter 0. Reset mid-write abandons the write; rows already written are zeroed along with the rest of the frame.
- States: IDLE, WRITE, DONE.
- in_ready = (state==IDLE) && !clear, combinational.
- Accept: in_valid && in_ready at a rising edge. At that edge the block latches win, row and col into internal registers. The input may change afterwards.
- Bounds check at accept: if row+K > M or col+K > M (computed at IW+1 bits), the window is rejected:
  - err=1 for the next cycle;
  - frame unchanged;
  - state stays IDLE;
  - no done pulse.
- In-bounds accept: go to WRITE with r=0.
- WRITE: on each edge, frame[row+r][col+c] <= win_latched[r][c] for c=0..K-1, then r increments. After r=K-1 is written, go to DONE.
- DONE: done=1 for exactly one cycle, in_ready=0, then return to IDLE.
- busy = (state != IDLE).
- Latency, with accept at edge e0:
  - rows updated at edges e1..eK;
  - done high between eK and eK+1;
  - next accept possible at edge eK+2.
  - Throughput: one window per K+2 cycles.
- Overlapping windows: a later window overwrites earlier values element-wise.
- Frame elements outside the window are never modified.
- clear in IDLE: all frame elements are zero at the next edge, and no accept happens that cycle. clear has priority over in_valid. clear during WRITE or DONE is ignored.
- frame is a direct register output; there is no bypass from win.

Optional Feature:
- Macro: WINDOW_WRITER_ACCUM_EN.
- Defined: each write does frame <= sat(frame + win), an unsigned W-bit add saturating at 2^W-1. Overlapping windows therefore accumulate.
- Undefined: plain overwrite as described above.
- Timing and handshake are identical in both builds.

Decomposition:
- Package window_pkg contains:
  - state enum ww_state_e {IDLE, WRITE, DONE};
  - function pos_width(M) returning the position index width;
  - function sat_add(a, b, W).
- K, M and W stay module parameters.
- One sub-module is natural: window_row_writer, which takes one latched window row, the base column and the enable, and produces the next-state values for one frame row (overwrite or saturating accumulate).
- The FSM and row counter stay in the top module.

Test Plan:
- Reset, then hold rst high mid-WRITE → frame all 0, in_ready=1, busy=0, done=0.
- K=3, M=8: window of values 1..9 at (0,0) → frame[0][0..2]=1,2,3 after edge 1; rows 1 and 2 after edges 2 and 3; done pulses once; frame[3][3]=0.
- Window at (5,5) (last legal position) → frame[7][7]=win[2][2]. Window at (6,0) → err pulse, frame unchanged, no done, in_ready stays 1.
- Back-to-back: in_valid held high → second accept occurs exactly K+2 cycles after the first; in_ready=0 throughout busy.
- clear and in_valid together in IDLE → frame zeroed, window not accepted, accepted on the next cycle. clear during WRITE → ignored.
- Overlap (all-200 window at (0,0), then all-100 window at (1,1)) → frame[1][1]=100 without WINDOW_WRITER_ACCUM_EN; 255 (saturated) with it; frame[0][0]=200 in both builds.
